// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: bus widths, MMIO register map
// and STATUS bit layout.
package data_mem_responder_pkg;

  localparam int RegBus     = 32;
  localparam int DataMemBus = 32;
  localparam int ByteSelBus = 4;

  localparam logic [3:0] MMIO_NIBBLE_DEFAULT = 4'h1;

  typedef enum logic [1:0] {
    REG_TX     = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYC_LO = 2'd2,
    REG_CYC_HI = 2'd3
  } mmio_reg_e;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

  function automatic logic [DataMemBus-1:0] lane_merge(
    input logic [DataMemBus-1:0] old_word,
    input logic [DataMemBus-1:0] new_word,
    input logic [ByteSelBus-1:0] sel
  );
    logic [DataMemBus-1:0] merged;
    merged = old_word;
    for (int i = 0; i < ByteSelBus; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory port; the memory stage is the master, the responder the slave.
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic                  ce;
  logic                  we;
  logic [RegBus-1:0]     addr;
  logic [ByteSelBus-1:0] sel;
  logic [DataMemBus-1:0] wdata;
  logic [DataMemBus-1:0] rdata;

  modport master (output ce, we, addr, sel, wdata, input rdata);
  modport slave  (input ce, we, addr, sel, wdata, output rdata);

endinterface

// File: rtl/data_mem_responder_console.sv
// Console transmit byte FIFO with wrap-bit pointers and a sticky overflow flag.
module console_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       ready,
  input  logic       clr_ovf,
  output logic [7:0] data,
  output logic       valid,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                pop;
  logic                push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign valid   = !empty;
  assign pop     = valid & ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push & (!full | pop);
  assign data    = empty ? 8'h00 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
      if (push & full & !pop) overflow <= 1'b1;
      else if (clr_ovf)       overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-enabled word RAM plus an MMIO window with the
// console FIFO and a free-running 64-bit cycle counter. Reads are combinational.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int         DEPTH_LOG2      = 10,
  parameter int         FIFO_DEPTH_LOG2 = 2,
  parameter logic [3:0] MMIO_NIBBLE     = MMIO_NIBBLE_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  data_mem_responder_if.slave         bus,
  output logic [7:0]                  con_data,
  output logic                        con_valid,
  input  logic                        con_ready
);

  localparam int WORDS = 2 ** DEPTH_LOG2;

  logic [DataMemBus-1:0] ram [WORDS];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  is_mmio;
  mmio_reg_e             reg_sel;
  logic                  rd_en;
  logic                  wr_en;
  logic [63:0]           count;
  logic [31:0]           snap_hi;
  logic                  fifo_push;
  logic                  fifo_clr_ovf;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_ovf;
  logic                  unused_addr;

  assign is_mmio  = (bus.addr[31:28] == MMIO_NIBBLE);
  assign word_idx = bus.addr[DEPTH_LOG2+1:2];
  assign reg_sel  = mmio_reg_e'(bus.addr[3:2]);
  assign rd_en    = bus.ce & !bus.we;
  assign wr_en    = bus.ce & bus.we;
  // Only parts of the address take part in decode; the rest aliases.
  assign unused_addr = ^bus.addr;

  assign fifo_push    = wr_en & is_mmio & (reg_sel == REG_TX) & bus.sel[0];
  assign fifo_clr_ovf = wr_en & is_mmio & (reg_sel == REG_STATUS) &
                        bus.sel[0] & bus.wdata[STAT_OVF];

  always_ff @(posedge clk) begin
    if (wr_en && !is_mmio && !rst) begin
      ram[word_idx] <= lane_merge(ram[word_idx], bus.wdata, bus.sel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      snap_hi <= '0;
    end else begin
      count <= count + 64'd1;
      if (rd_en && is_mmio && reg_sel == REG_CYC_LO) snap_hi <= count[63:32];
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (rd_en) begin
      if (is_mmio) begin
        case (reg_sel)
          REG_TX:     bus.rdata = '0;
          REG_STATUS: begin
            bus.rdata[STAT_EMPTY] = fifo_empty;
            bus.rdata[STAT_FULL]  = fifo_full;
            bus.rdata[STAT_OVF]   = fifo_ovf;
          end
          REG_CYC_LO: bus.rdata = count[31:0];
          REG_CYC_HI: bus.rdata = snap_hi;
          default:    bus.rdata = '0;
        endcase
      end else begin
        bus.rdata = ram[word_idx];
      end
    end
  end

  console_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_console_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bus.wdata[7:0]),
    .ready     (con_ready),
    .clr_ovf   (fifo_clr_ovf),
    .data      (con_data),
    .valid     (con_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf)
  );

endmodule
